// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Fully pipelined LSL/LSR/ASR/ROR barrel shifter, one stage per
//               amount bit, valid-qualified. Optional amount saturation via
//               the macro BARREL_SHIFTER_SAT_AMT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    input  logic [N-1:0]         arg_a,
    input  logic [$clog2(N):0]   arg_amt,
    input  logic [1:0]           arg_mode,
    output logic                 res_vld,
    output logic [N-1:0]         res
);

    localparam int AW = $clog2(N) + 1;
    localparam int L  = $clog2(N);

    localparam logic [1:0] c_LSL = 2'b00;
    localparam logic [1:0] c_LSR = 2'b01;
    localparam logic [1:0] c_ASR = 2'b10;
    localparam logic [1:0] c_ROR = 2'b11;

    // Index k is the input of stage k; index L is the pipeline output.
    logic [L:0]         w_vld;
    logic [L:0][N-1:0]  w_data;
    logic [L:0][1:0]    w_mode;
    logic [L:0][AW-1:0] w_amt;

    assign w_vld[0]  = arg_vld;
    assign w_data[0] = arg_a;
    assign w_mode[0] = arg_mode;
    assign w_amt[0]  = arg_amt;

    assign res_vld = w_vld[L];
    assign res     = w_data[L];

    // Consumed amount bits and the final mode are intentionally left dangling.
    logic w_unused;
    assign w_unused = ^{w_amt, w_mode};

    function automatic logic [N-1:0] f_shift(input logic [N-1:0] d,
                                             input logic [1:0]   mode,
                                             input int           sh);
        logic [N-1:0] r;
        case (mode)
            c_LSL:   r = d << sh;
            c_LSR:   r = d >> sh;
            c_ASR:   r = $signed(d) >>> sh;
            default: r = (d >> sh) | (d << (N - sh));
        endcase
        return r;
    endfunction

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic         r_vld;
        logic [N-1:0] r_data;
        logic [1:0]   r_mode;
        logic [AW-1:0] r_amt;
        logic [N-1:0] w_next;

        always_comb begin
            w_next = w_data[k];
            if (w_amt[k][k]) begin
                w_next = f_shift(w_data[k], w_mode[k], 1 << k);
            end
`ifdef BARREL_SHIFTER_SAT_AMT_EN
            // ASR keeps the sign in the MSB through every stage, so it is
            // still the original operand sign here.
            if ((k == L - 1) && w_amt[k][AW-1] && (w_mode[k] != c_ROR)) begin
                w_next = (w_mode[k] == c_ASR) ? {N{w_data[k][N-1]}} : '0;
            end
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_mode <= '0;
                r_amt  <= '0;
            end else begin
                r_vld <= w_vld[k];
                if (w_vld[k]) begin
                    r_data <= w_next;
                    r_mode <= w_mode[k];
                    r_amt  <= w_amt[k];
                end
            end
        end

        assign w_vld[k+1]  = r_vld;
        assign w_data[k+1] = r_data;
        assign w_mode[k+1] = r_mode;
        assign w_amt[k+1]  = r_amt;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Self-checking bench for pipelined_barrel_shifter (N=8, N=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        arg_vld;
    logic [7:0]  arg_a;
    logic [3:0]  arg_amt;
    logic [1:0]  arg_mode;
    logic        res_vld;
    logic [7:0]  res;

    logic        b_vld;
    logic [31:0] b_a;
    logic [5:0]  b_amt;
    logic [1:0]  b_mode;
    logic        b_res_vld;
    logic [31:0] b_res;

    int n_pass  = 0;
    int n_total = 0;

    pipelined_barrel_shifter #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_a(arg_a),
        .arg_amt(arg_amt), .arg_mode(arg_mode), .res_vld(res_vld), .res(res)
    );

    pipelined_barrel_shifter #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .arg_vld(b_vld), .arg_a(b_a),
        .arg_amt(b_amt), .arg_mode(b_mode), .res_vld(b_res_vld), .res(b_res)
    );

    // Bit-by-bit definition of each shift mode: result bit i takes its value
    // from operand bit i-amt / i+amt, or the fill value when that is outside.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int amt_in,
                                              input int mode, input int n);
        logic [31:0] r;
        logic        sign;
        int          amt;
        int          src;
        bit          sat;
        r    = '0;
        sign = a[n-1];
        amt  = amt_in % n;
        sat  = 1'b0;
`ifdef BARREL_SHIFTER_SAT_AMT_EN
        sat = (amt_in >= n) && (mode != 3);
`endif
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin
                    src = i - amt;
                    if (src >= 0) r[i] = a[src]; else r[i] = 1'b0;
                end
                1: begin
                    src = i + amt;
                    if (src < n) r[i] = a[src]; else r[i] = 1'b0;
                end
                2: begin
                    src = i + amt;
                    if (src < n) r[i] = a[src]; else r[i] = sign;
                end
                default: r[i] = a[(i + amt) % n];
            endcase
            if (sat) r[i] = (mode == 2) ? sign : 1'b0;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] a,
                          input logic [3:0] amt, input logic [1:0] m);
        arg_vld  = v;
        arg_a    = a;
        arg_amt  = amt;
        arg_mode = m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 8'hFF, 4'd1, 2'b00);
        step();
        step();
        n_total++; if (res_vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", res_vld); else n_pass++;
        n_total++; if (res !== 8'h00) $display("FAIL reset_res: got %h expected 00", res); else n_pass++;
        n_total++; if (b_res_vld !== 1'b0) $display("FAIL reset_vld32: got %b expected 0", b_res_vld); else n_pass++;
        n_total++; if (b_res !== 32'h0) $display("FAIL reset_res32: got %h expected 0", b_res); else n_pass++;
        rst = 1'b0;
        set_in(1'b0, 8'h00, 4'd0, 2'b00);
        for (int c = 0; c < 4; c++) begin
            step();
            n_total++; if (res_vld !== 1'b0) $display("FAIL reset_drop_vld: got %b expected 0", res_vld); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_r [4] = '{8'h90, 8'h16, 8'hF6, 8'h56};
        logic       ev;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) set_in(1'b1, 8'hB2, 4'd3, 2'(c - 1));
            else        set_in(1'b0, 8'h00, 4'd0, 2'b00);
            step();
            ev = (c >= 3) && (c <= 6);
            n_total++; if (res_vld !== ev) $display("FAIL b2b_vld c=%0d: got %b expected %b", c, res_vld, ev); else n_pass++;
            if (ev) begin
                n_total++; if (res !== exp_r[c-3]) $display("FAIL b2b_res c=%0d: got %h expected %h", c, res, exp_r[c-3]); else n_pass++;
            end
        end
    endtask

    task automatic test_amt_edges();
        logic [7:0] in_a [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h80, 8'h80};
        logic [3:0] in_n [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd7};
        logic [1:0] in_m [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
        logic [7:0] exp_r [6] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'h01};
        logic       ev;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 6) set_in(1'b1, in_a[c-1], in_n[c-1], in_m[c-1]);
            else        set_in(1'b0, 8'h00, 4'd0, 2'b00);
            step();
            ev = (c >= 3);
            n_total++; if (res_vld !== ev) $display("FAIL edge_vld c=%0d: got %b expected %b", c, res_vld, ev); else n_pass++;
            if (ev) begin
                n_total++; if (res !== exp_r[c-3]) $display("FAIL edge_res c=%0d: got %h expected %h", c, res, exp_r[c-3]); else n_pass++;
            end
        end
    endtask

    task automatic test_bubbles();
        logic       pat  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] in_a [5] = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h08};
        logic [7:0] hold [5] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04};
        logic       ev;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 5) set_in(pat[c-1], in_a[c-1], 4'd1, 2'b01);
            else        set_in(1'b0, 8'h00, 4'd0, 2'b00);
            step();
            ev = (c >= 3) ? pat[c-3] : 1'b0;
            n_total++; if (res_vld !== ev) $display("FAIL bubble_vld c=%0d: got %b expected %b", c, res_vld, ev); else n_pass++;
            if (c >= 3) begin
                n_total++; if (res !== hold[c-3]) $display("FAIL bubble_res c=%0d: got %h expected %h", c, res, hold[c-3]); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic       ev_v [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] ev_r [5] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h02};
        for (int c = 1; c <= 7; c++) begin
            rst = (c == 3);
            case (c)
                1: set_in(1'b1, 8'h10, 4'd1, 2'b01);
                2: set_in(1'b1, 8'h20, 4'd1, 2'b01);
                3: set_in(1'b1, 8'h40, 4'd1, 2'b01);
                4: set_in(1'b1, 8'h01, 4'd1, 2'b00);
                default: set_in(1'b0, 8'h00, 4'd0, 2'b00);
            endcase
            step();
            n_total++; if (res_vld !== ev_v[c-1]) $display("FAIL rstmid_vld c=%0d: got %b expected %b", c, res_vld, ev_v[c-1]); else n_pass++;
            if (c >= 3) begin
                n_total++; if (res !== ev_r[c-3]) $display("FAIL rstmid_res c=%0d: got %h expected %h", c, res, ev_r[c-3]); else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_amt_msb();
`ifdef BARREL_SHIFTER_SAT_AMT_EN
        logic [7:0] exp_r [4] = '{8'h00, 8'h00, 8'hFF, 8'h59};
`else
        logic [7:0] exp_r [4] = '{8'h64, 8'h59, 8'hD9, 8'h59};
`endif
        logic ev;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) set_in(1'b1, 8'hB2, 4'd9, 2'(c - 1));
            else        set_in(1'b0, 8'h00, 4'd0, 2'b00);
            step();
            ev = (c >= 3);
            n_total++; if (res_vld !== ev) $display("FAIL msb_vld c=%0d: got %b expected %b", c, res_vld, ev); else n_pass++;
            if (ev) begin
                n_total++; if (res !== exp_r[c-3]) $display("FAIL msb_res mode=%0d: got %h expected %h", c - 3, res, exp_r[c-3]); else n_pass++;
            end
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    task automatic test_random();
        exp_t        q8[$];
        exp_t        q32[$];
        exp_t        e;
        int          sent8 = 0;
        int          sent32 = 0;
        int          seen8 = 0;
        int          seen32 = 0;
        int          err8 = 0;
        int          err32 = 0;
        logic        v8;
        logic [7:0]  a8;
        logic [3:0]  n8;
        logic [1:0]  m8;
        logic        v32;
        logic [31:0] a32;
        logic [5:0]  n32;
        logic [1:0]  m32;
        for (int cyc = 0; cyc < 2008; cyc++) begin
            if (cyc < 2000) begin
                v8  = ($urandom_range(0, 3) != 0);
                a8  = 8'($urandom);
                n8  = 4'($urandom);
                m8  = 2'($urandom);
                v32 = ($urandom_range(0, 3) != 0);
                a32 = $urandom;
                n32 = 6'($urandom);
                m32 = 2'($urandom);
            end else begin
                v8  = 1'b0; a8  = '0; n8  = '0; m8  = '0;
                v32 = 1'b0; a32 = '0; n32 = '0; m32 = '0;
            end
            set_in(v8, a8, n8, m8);
            b_vld  = v32;
            b_a    = a32;
            b_amt  = n32;
            b_mode = m32;
            e.v = v8;
            e.d = ref_shift({24'h0, a8}, int'(n8), int'(m8), 8);
            q8.push_back(e);
            if (v8) sent8++;
            e.v = v32;
            e.d = ref_shift(a32, int'(n32), int'(m32), 32);
            q32.push_back(e);
            if (v32) sent32++;
            step();
            if (q8.size() == 3) begin
                e = q8.pop_front();
                if (res_vld !== e.v) begin
                    err8++;
                    $display("FAIL rand8_vld cyc=%0d: got %b expected %b", cyc, res_vld, e.v);
                end else if (e.v) begin
                    seen8++;
                    if (res !== e.d[7:0]) begin
                        err8++;
                        $display("FAIL rand8_res cyc=%0d: got %h expected %h", cyc, res, e.d[7:0]);
                    end
                end
            end
            if (q32.size() == 5) begin
                e = q32.pop_front();
                if (b_res_vld !== e.v) begin
                    err32++;
                    $display("FAIL rand32_vld cyc=%0d: got %b expected %b", cyc, b_res_vld, e.v);
                end else if (e.v) begin
                    seen32++;
                    if (b_res !== e.d) begin
                        err32++;
                        $display("FAIL rand32_res cyc=%0d: got %h expected %h", cyc, b_res, e.d);
                    end
                end
            end
        end
        b_vld = 1'b0;
        n_total++; if (err8 != 0) $display("FAIL rand8_mismatches: got %0d expected 0", err8); else n_pass++;
        n_total++; if (err32 != 0) $display("FAIL rand32_mismatches: got %0d expected 0", err32); else n_pass++;
        n_total++; if (seen8 != sent8) $display("FAIL rand8_count: got %0d expected %0d", seen8, sent8); else n_pass++;
        n_total++; if (seen32 != sent32) $display("FAIL rand32_count: got %0d expected %0d", seen32, sent32); else n_pass++;
        n_total++; if (sent8 < 1000) $display("FAIL rand8_ops: got %0d expected >= 1000", sent8); else n_pass++;
        n_total++; if (sent32 < 1000) $display("FAIL rand32_ops: got %0d expected >= 1000", sent32); else n_pass++;
    endtask

    initial begin
        rst    = 1'b1;
        b_vld  = 1'b0;
        b_a    = '0;
        b_amt  = '0;
        b_mode = '0;
        set_in(1'b0, 8'h00, 4'd0, 2'b00);
        test_reset();
        test_back_to_back();
        test_amt_edges();
        test_bubbles();
        test_reset_midflight();
        test_amt_msb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
